// File: rtl/input_conditioner_if.sv
// Bundle of the raw board inputs and the conditioned outputs for input_conditioner.
// The master side drives the pins. The slave side is the conditioner.
interface input_conditioner_if #(
  parameter int width = 4
);
  logic [width-1:0] async_in;
  logic [width-1:0] debounced;
  logic [width-1:0] rise_pulse;
  logic [width-1:0] fall_pulse;

  modport master (
    output async_in,
    input  debounced,
    input  rise_pulse,
    input  fall_pulse
  );

  modport slave (
    input  async_in,
    output debounced,
    output rise_pulse,
    output fall_pulse
  );
endinterface

// File: rtl/input_conditioner.sv
// Per-bit two-flop synchronizer, shared sample tick and symmetric debounce, plus edge pulses.
// Latency: 2 + up to sample_cnt_max*pulse_cnt_max cycles. There is no backpressure; inputs are sampled every cycle.
module input_conditioner #(
  parameter int width          = 4,
  parameter int sample_cnt_max = 25000,
  parameter int pulse_cnt_max  = 150
) (
  input  logic                clk,
  input  logic                rst,
  input_conditioner_if.slave  bus
);

  localparam int TW = (sample_cnt_max > 1) ? $clog2(sample_cnt_max) : 1;
  localparam int CW = (pulse_cnt_max > 1) ? $clog2(pulse_cnt_max) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(sample_cnt_max - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(pulse_cnt_max - 1);

  logic [width-1:0] s1;
  logic [width-1:0] s2;
  logic [width-1:0] deb;
  logic [width-1:0] deb_d;
  logic [TW-1:0]    tick_cnt;
  logic [CW-1:0]    cnt [width];
  logic             sample_tick;

  assign sample_tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      deb      <= '0;
      deb_d    <= '0;
      tick_cnt <= '0;
      for (int i = 0; i < width; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1       <= bus.async_in;
      s2       <= s1;
      deb_d    <= deb;
      tick_cnt <= sample_tick ? '0 : tick_cnt + TW'(1);
      for (int i = 0; i < width; i++) begin
        // Agreement restarts the count on any cycle, even one that carries a tick.
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (sample_tick) begin
          if (cnt[i] == PULSE_LAST) begin
            deb[i] <= ~deb[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end
      end
    end
  end

  assign bus.debounced  = deb;
  assign bus.rise_pulse = deb & ~deb_d;
  assign bus.fall_pulse = ~deb & deb_d;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: main instance (width=2, tick=4, pulses=3)
// and a degenerate instance (tick=1, pulses=1) sharing clock and reset.
module tb_input_conditioner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   e     = 0;

  always #5 clk = ~clk;

  input_conditioner_if #(.width(2)) a_if ();
  input_conditioner_if #(.width(2)) b_if ();

  input_conditioner #(.width(2), .sample_cnt_max(4), .pulse_cnt_max(3)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  input_conditioner #(.width(2), .sample_cnt_max(1), .pulse_cnt_max(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  // Advance to 1 time unit after the given edge, counted from reset release.
  task automatic to_edge(input int k);
    while (e < k) begin
      @(posedge clk);
      e++;
    end
    #1;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    e = 0;
  endtask

  task automatic apply_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    a_if.async_in = 2'b00;
    b_if.async_in = 2'b00;
    #12;
    chk("reset_deb", a_if.debounced, 2'b00);
    chk("reset_rise", a_if.rise_pulse, 2'b00);
    chk("reset_fall", a_if.fall_pulse, 2'b00);
    chk("reset_tick_cnt", dut_a.tick_cnt, 0);

    // Press debounce on bit 0, degenerate instance stimulated alongside.
    a_if.async_in = 2'b01;
    b_if.async_in = 2'b01;
    release_rst();
    to_edge(1);
    chk("sync_lat_e1", dut_a.s2, 2'b00);
    to_edge(2);
    chk("sync_e2", dut_a.s2, 2'b01);
    chk("degen_deb_e2", b_if.debounced, 2'b00);
    to_edge(3);
    chk("degen_deb_e3", b_if.debounced, 2'b01);
    chk("degen_rise_e3", b_if.rise_pulse, 2'b01);
    to_edge(4);
    chk("press_cnt_e4", dut_a.cnt[0], 1);
    chk("degen_rise_e4", b_if.rise_pulse, 2'b00);
    to_edge(7);
    chk("press_cnt_e7", dut_a.cnt[0], 1);
    to_edge(8);
    chk("press_cnt_e8", dut_a.cnt[0], 2);
    to_edge(11);
    chk("press_deb_e11", a_if.debounced, 2'b00);
    chk("press_rise_e11", a_if.rise_pulse, 2'b00);
    to_edge(12);
    chk("press_deb_e12", a_if.debounced, 2'b01);
    chk("press_rise_e12", a_if.rise_pulse, 2'b01);
    chk("press_fall_e12", a_if.fall_pulse, 2'b00);
    chk("press_cnt_e12", dut_a.cnt[0], 0);
    to_edge(13);
    chk("press_rise_e13", a_if.rise_pulse, 2'b00);
    chk("press_deb_e13", a_if.debounced, 2'b01);

    // Release debounce.
    to_edge(20);
    a_if.async_in = 2'b00;
    b_if.async_in = 2'b00;
    to_edge(23);
    chk("degen_fall_e23", b_if.fall_pulse, 2'b01);
    to_edge(31);
    chk("rel_deb_e31", a_if.debounced, 2'b01);
    chk("rel_fall_e31", a_if.fall_pulse, 2'b00);
    to_edge(32);
    chk("rel_deb_e32", a_if.debounced, 2'b00);
    chk("rel_fall_e32", a_if.fall_pulse, 2'b01);
    chk("rel_rise_e32", a_if.rise_pulse, 2'b00);
    to_edge(33);
    chk("rel_fall_e33", a_if.fall_pulse, 2'b00);

    // Glitch rejection: high for edges 1..6 only.
    apply_rst();
    a_if.async_in = 2'b01;
    release_rst();
    to_edge(6);
    a_if.async_in = 2'b00;
    to_edge(8);
    chk("glitch_cnt_e8", dut_a.cnt[0], 2);
    to_edge(9);
    chk("glitch_cnt_e9", dut_a.cnt[0], 0);
    for (int k = 10; k <= 20; k++) begin
      to_edge(k);
      chk("glitch_deb", a_if.debounced, 2'b00);
      chk("glitch_pulses", {a_if.rise_pulse, a_if.fall_pulse}, 4'b0000);
    end
    chk("glitch_cnt_e20", dut_a.cnt[0], 0);

    // Both bits together.
    apply_rst();
    a_if.async_in = 2'b11;
    release_rst();
    to_edge(11);
    chk("both_deb_e11", a_if.debounced, 2'b00);
    to_edge(12);
    chk("both_deb_e12", a_if.debounced, 2'b11);
    chk("both_rise_e12", a_if.rise_pulse, 2'b11);
    to_edge(13);
    chk("both_rise_e13", a_if.rise_pulse, 2'b00);

    // Asynchronous reset while debounced is high: clears with no edge, no fall pulse.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_deb", a_if.debounced, 2'b00);
    chk("arst_fall", a_if.fall_pulse, 2'b00);
    chk("arst_rise", a_if.rise_pulse, 2'b00);

    // Mid-count reset: bit 0 pressed, reset between edges 9 and 10.
    a_if.async_in = 2'b01;
    release_rst();
    to_edge(1);
    chk("post_rst_fall", a_if.fall_pulse, 2'b00);
    to_edge(9);
    chk("mid_cnt_e9", dut_a.cnt[0], 2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_cnt", dut_a.cnt[0], 0);
    chk("mid_rst_tick", dut_a.tick_cnt, 0);
    chk("mid_rst_out", {a_if.debounced, a_if.rise_pulse, a_if.fall_pulse}, 6'd0);
    @(negedge clk);
    release_rst();
    to_edge(11);
    chk("mid_deb_e11", a_if.debounced, 2'b00);
    to_edge(12);
    chk("mid_deb_e12", a_if.debounced, 2'b01);
    chk("mid_rise_e12", a_if.rise_pulse, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
